// File: rtl/cart_bus_master.sv
// Cartridge bus initiator: queues host byte requests and replays them as CPU-timed
// cart cycles (setup / strobe / hold) against the mapper, returning one response per request.
module cart_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CE   = 1,
  parameter int STROBE_CE  = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic        ce_cpu2x,
  input  logic        speed,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_oe,
  output logic        busy,
  output logic [14:0] cart_addr,
  output logic        cart_a15,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [7:0]  cart_di,
  output logic        nCS,
  input  logic [7:0]  rom_do,
  input  logic [7:0]  cram_do,
  input  logic        cart_oe
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (SETUP_CE > STROBE_CE) ? SETUP_CE : STROBE_CE;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CE - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  logic ce;
  assign ce = speed ? ce_cpu2x : ce_cpu;

  // Request FIFO: {write, addr[15:0], data[7:0]}; head is read combinationally so IDLE can pop it at once.
  logic [24:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [24:0] head;
  logic        head_write;
  logic [15:0] head_addr;
  logic [7:0]  head_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_write = head[24];
  assign head_addr  = head[23:8];
  assign head_data  = head[7:0];

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {req_write, req_addr, req_data};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [14:0]   cart_addr_q, cart_addr_d;
  logic          cart_a15_q, cart_a15_d;
  logic          ncs_q, ncs_d;
  logic [7:0]    cart_di_q, cart_di_d;
  logic          cart_rd_q, cart_rd_d;
  logic          cart_wr_q, cart_wr_d;
  logic [7:0]    data_q, data_d;
  logic          oe_q, oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_oe_q, rsp_oe_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      cart_addr_q <= '0;
      cart_a15_q  <= 1'b0;
      ncs_q       <= 1'b1;
      cart_di_q   <= '0;
      cart_rd_q   <= 1'b0;
      cart_wr_q   <= 1'b0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      cart_addr_q <= cart_addr_d;
      cart_a15_q  <= cart_a15_d;
      ncs_q       <= ncs_d;
      cart_di_q   <= cart_di_d;
      cart_rd_q   <= cart_rd_d;
      cart_wr_q   <= cart_wr_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_oe_q    <= rsp_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    cart_addr_d = cart_addr_q;
    cart_a15_d  = cart_a15_q;
    ncs_d       = ncs_q;
    cart_di_d   = cart_di_q;
    cart_rd_d   = cart_rd_q;
    cart_wr_d   = cart_wr_q;
    data_d      = data_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_oe_d    = rsp_oe_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Holding off while rsp_valid is up keeps the next request one clock behind the response.
        if (!fifo_empty && !rsp_valid_q) begin
          pop = 1'b1;
          if (head_addr[15:14] == 2'b11) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'hFF;
            rsp_oe_d    = 1'b0;
          end else begin
            state_d     = ST_SETUP;
            cnt_d       = '0;
            is_wr_d     = head_write;
            cart_addr_d = head_addr[14:0];
            cart_a15_d  = head_addr[15];
            ncs_d       = !(head_addr[15:13] == 3'b101);
            cart_di_d   = head_write ? head_data : 8'h00;
            data_d      = 8'h00;
            oe_d        = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        if (ce) begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d     = '0;
            state_d   = ST_STROBE;
            cart_rd_d = !is_wr_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_STROBE: begin
        if (is_wr_q) begin
          // Raise cart_wr one clock after entry and drop it after the first ce it meets.
          if (!cart_wr_q) begin
            cart_wr_d = 1'b1;
          end else if (ce) begin
            cart_wr_d = 1'b0;
            state_d   = ST_HOLD;
          end
        end else if (ce) begin
          if (cnt_q == STROBE_LAST) begin
            cnt_d     = '0;
            cart_rd_d = 1'b0;
            data_d    = ncs_q ? rom_do : cram_do;
            oe_d      = cart_oe;
            state_d   = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (ce) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_q;
          rsp_oe_d    = oe_q;
          is_wr_d     = 1'b0;
          cart_addr_d = '0;
          cart_a15_d  = 1'b0;
          ncs_d       = 1'b1;
          cart_di_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_oe    = rsp_oe_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign cart_addr = cart_addr_q;
  assign cart_a15  = cart_a15_q;
  assign cart_rd   = cart_rd_q;
  assign cart_wr   = cart_wr_q;
  assign cart_di   = cart_di_q;
  assign nCS       = ncs_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master: vector table of single transactions plus
// FIFO-full, rejected-latency, reset-abort and double-speed sequences.
module tb_cart_bus_master;

  logic        clk_sys = 1'b0;
  logic        reset, ce_cpu, ce_cpu2x, speed;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid, rsp_oe, busy;
  logic [7:0]  rsp_data;
  logic [14:0] cart_addr;
  logic        cart_a15, cart_rd, cart_wr, nCS;
  logic [7:0]  cart_di;
  logic [7:0]  rom_do, cram_do;
  logic        cart_oe;

  logic        rom_mode;
  logic [7:0]  rom_val, cram_val;
  logic        oe_val;
  logic        ce_sel;
  logic [1:0]  phase;

  always #5 clk_sys = ~clk_sys;

  assign rom_do  = rom_mode ? (cart_addr[7:0] ^ 8'hA5) : rom_val;
  assign cram_do = cram_val;
  assign cart_oe = oe_val;
  assign ce_sel  = speed ? ce_cpu2x : ce_cpu;

  cart_bus_master #(.FIFO_DEPTH(4), .SETUP_CE(1), .STROBE_CE(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .ce_cpu2x(ce_cpu2x), .speed(speed),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_oe(rsp_oe), .busy(busy),
    .cart_addr(cart_addr), .cart_a15(cart_a15), .cart_rd(cart_rd), .cart_wr(cart_wr),
    .cart_di(cart_di), .nCS(nCS), .rom_do(rom_do), .cram_do(cram_do), .cart_oe(cart_oe)
  );

  // ce_cpu every 4th clock, ce_cpu2x every 2nd clock.
  initial begin
    phase = 2'd0; ce_cpu = 1'b0; ce_cpu2x = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      phase    = phase + 2'd1;
      ce_cpu   = (phase == 2'd0);
      ce_cpu2x = (phase[0] == 1'b0);
    end
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int          rd_ce_n = 0, wr_ce_n = 0, act_n = 0, rsp_n = 0;
  logic [14:0] mon_addr = '0;
  logic        mon_a15 = 1'b0, mon_ncs = 1'b1;
  logic [7:0]  mon_di = '0;
  logic [8:0]  rsp_log [256];
  int          rsp_cyc [256];

  always @(negedge clk_sys) begin
    if (ce_sel && cart_rd) rd_ce_n = rd_ce_n + 1;
    if (ce_sel && cart_wr) wr_ce_n = wr_ce_n + 1;
    if (cart_rd || cart_wr || !nCS) act_n = act_n + 1;
    if (cart_rd || cart_wr) begin
      mon_addr = cart_addr; mon_a15 = cart_a15; mon_ncs = nCS; mon_di = cart_di;
    end
    if (rsp_valid) begin
      rsp_log[rsp_n[7:0]] = {rsp_oe, rsp_data};
      rsp_cyc[rsp_n[7:0]] = cyc;
      rsp_n = rsp_n + 1;
    end
  end

  int n_chk = 0, n_err = 0;
  int push_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d);
    int k;
    k = 0;
    while (!req_ready && k < 300) begin step(1); k++; end
    if (!req_ready) check("push_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    @(posedge clk_sys); #1;
    push_cyc  = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input int bound);
    int k;
    k = 0;
    while (rsp_n <= idx && k < bound) begin step(1); k++; end
    if (rsp_n <= idx) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data, rom, cram;
    logic        oe, rej, a15;
    logic [14:0] xaddr;
    logic        ncs;
    logic [7:0]  di, rdata;
    logic        roe;
    int          rdce, wrce;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int base, r0, w0, a0, lat0, lat1;
    bit early;
    logic [7:0] exp_b;

    //            wr    addr      data   rom    cram   oe    rej   a15   xaddr      ncs   di     rdata  roe  rd wr
    vecs[0] = '{1'b0, 16'h0150, 8'h00, 8'h3C, 8'hAA, 1'b1, 1'b0, 1'b0, 15'h0150, 1'b1, 8'h00, 8'h3C, 1'b1, 2, 0};
    vecs[1] = '{1'b1, 16'h2000, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 15'h2000, 1'b1, 8'h05, 8'h00, 1'b0, 0, 1};
    vecs[2] = '{1'b0, 16'hA123, 8'h00, 8'h11, 8'h7E, 1'b1, 1'b0, 1'b1, 15'h2123, 1'b0, 8'h00, 8'h7E, 1'b1, 2, 0};
    vecs[3] = '{1'b1, 16'hA000, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 15'h2000, 1'b0, 8'h5A, 8'h00, 1'b0, 0, 1};
    vecs[4] = '{1'b0, 16'h4000, 8'h00, 8'h99, 8'h22, 1'b0, 1'b0, 1'b0, 15'h4000, 1'b1, 8'h00, 8'h99, 1'b0, 2, 0};
    vecs[5] = '{1'b0, 16'h8000, 8'h00, 8'h12, 8'hEE, 1'b1, 1'b0, 1'b1, 15'h0000, 1'b1, 8'h00, 8'h12, 1'b1, 2, 0};
    vecs[6] = '{1'b0, 16'hBFFF, 8'h00, 8'h56, 8'h34, 1'b1, 1'b0, 1'b1, 15'h3FFF, 1'b0, 8'h00, 8'h34, 1'b1, 2, 0};
    vecs[7] = '{1'b0, 16'hC000, 8'h00, 8'h77, 8'h77, 1'b1, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h00, 8'hFF, 1'b0, 0, 0};
    vecs[8] = '{1'b1, 16'hFF80, 8'h42, 8'h77, 8'h77, 1'b1, 1'b1, 1'b0, 15'h0000, 1'b1, 8'h00, 8'hFF, 1'b0, 0, 0};

    reset = 1'b1; speed = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    rom_mode = 1'b0; rom_val = '0; cram_val = '0; oe_val = 1'b0;
    step(3);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_oe", rsp_oe, 1'b0);
    check("rst_strobes", {cart_rd, cart_wr}, 2'b00);
    check("rst_cart_di", cart_di, 8'h00);
    check("rst_cart_addr", {cart_a15, cart_addr}, 16'h0000);
    check("rst_nCS", nCS, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    step(2);

    for (int i = 0; i < 9; i++) begin
      rom_val = vecs[i].rom; cram_val = vecs[i].cram; oe_val = vecs[i].oe;
      base = rsp_n; r0 = rd_ce_n; w0 = wr_ce_n; a0 = act_n;
      push(vecs[i].wr, vecs[i].addr, vecs[i].data);
      wait_rsp(base, 200);
      $display("vec %0d: %s addr=%04h data=%02h -> rsp_data=%02h rsp_oe=%0b rd_ce=%0d wr_ce=%0d",
               i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].data, rsp_log[base[7:0]][7:0],
               rsp_log[base[7:0]][8], rd_ce_n - r0, wr_ce_n - w0);
      check($sformatf("v%0d_rsp_data", i), rsp_log[base[7:0]][7:0], vecs[i].rdata);
      check($sformatf("v%0d_rsp_oe", i), rsp_log[base[7:0]][8], vecs[i].roe);
      check($sformatf("v%0d_rd_ce", i), rd_ce_n - r0, vecs[i].rdce);
      check($sformatf("v%0d_wr_ce", i), wr_ce_n - w0, vecs[i].wrce);
      if (vecs[i].rej) begin
        check($sformatf("v%0d_no_activity", i), act_n - a0, 0);
        check($sformatf("v%0d_rej_latency", i), rsp_cyc[base[7:0]] - push_cyc, 1);
      end else begin
        check($sformatf("v%0d_cart_addr", i), {mon_a15, mon_addr}, {vecs[i].a15, vecs[i].xaddr});
        check($sformatf("v%0d_nCS", i), mon_ncs, vecs[i].ncs);
        check($sformatf("v%0d_cart_di", i), mon_di, vecs[i].di);
      end
      step(2);
    end

    // Five back-to-back reads: the first is popped at once, the other four fill the FIFO.
    rom_mode = 1'b1; oe_val = 1'b1;
    base = rsp_n;
    req_valid = 1'b1; req_write = 1'b0; req_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      req_addr = 16'h0010 + 16'(i);
      check($sformatf("fill_ready_%0d", i), req_ready, 1'b1);
      @(posedge clk_sys); #1;
    end
    req_valid = 1'b0;
    check("full_after_5_pushes", req_ready, 1'b0);
    early = 1'b0;
    for (int k = 0; k < 300 && rsp_n <= base; k++) begin
      if (req_ready) early = 1'b1;
      step(1);
    end
    check("ready_held_until_pop", early, 1'b0);
    wait_rsp(base + 4, 400);
    for (int i = 0; i < 5; i++) begin
      exp_b = (8'h10 + 8'(i)) ^ 8'hA5;
      $display("burst %0d: rsp_data=%02h rsp_oe=%0b", i, rsp_log[(base + i) % 256][7:0], rsp_log[(base + i) % 256][8]);
      check($sformatf("burst_%0d_data", i), rsp_log[(base + i) % 256], {1'b1, exp_b});
    end
    rom_mode = 1'b0;
    step(2);

    // Single-speed vs double-speed read latency.
    rom_val = 8'h3C; speed = 1'b0;
    base = rsp_n;
    push(1'b0, 16'h0150, 8'h00);
    wait_rsp(base, 200);
    lat0 = rsp_cyc[base[7:0]] - push_cyc;
    step(2);
    speed = 1'b1;
    base = rsp_n;
    push(1'b0, 16'h0150, 8'h00);
    wait_rsp(base, 200);
    lat1 = rsp_cyc[base[7:0]] - push_cyc;
    $display("speed: lat_1x=%0d lat_2x=%0d clocks", lat0, lat1);
    check("lat_1x_range", (lat0 >= 14 && lat0 <= 17), 1'b1);
    check("lat_2x_range", (lat1 >= 8 && lat1 <= 9), 1'b1);
    check("lat_2x_data", rsp_log[base[7:0]], {1'b1, 8'h3C});
    speed = 1'b0;
    step(2);

    // Reset while the write strobe is up, two reads queued behind it.
    base = rsp_n;
    push(1'b1, 16'h2000, 8'h77);
    push(1'b0, 16'h0100, 8'h00);
    push(1'b0, 16'h0200, 8'h00);
    for (int k = 0; k < 200 && !cart_wr; k++) step(1);
    check("abort_saw_wr", cart_wr, 1'b1);
    reset = 1'b1;
    step(1);
    check("abort_wr_dropped", cart_wr, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_bus_idle", {nCS, cart_a15, cart_addr, cart_di}, {1'b1, 16'h0000, 8'h00});
    reset = 1'b0;
    a0 = act_n;
    step(60);
    $display("abort: responses=%0d busy=%0b activity=%0d", rsp_n - base, busy, act_n - a0);
    check("abort_no_rsp", rsp_n - base, 0);
    check("abort_stays_idle", {busy, 31'(act_n - a0)}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
